// File: rtl/poly_voice_mixer.sv
// poly_voice_mixer: N-voice serial multiply-accumulate mixer feeding the I2S serializer.
// Each FSCLK rise snapshots all voices, mixes them one per cycle, then scales and saturates.
module poly_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 7,
    parameter int OUT_W      = 16
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           FSCLK,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] VoiceSample,
    input  logic [NUM_VOICES*GAIN_W-1:0]   VoiceGain,
    input  logic [NUM_VOICES-1:0]          VoiceEnable,
    input  logic                           Clear_Flags,
    output logic signed [OUT_W-1:0]       Mix_Out,
    output logic                           Mix_Valid,
    output logic                           Busy,
    output logic                           Clip,
    output logic                           Overrun
);

    localparam int ACC_W  = SAMPLE_W + GAIN_W + $clog2(NUM_VOICES) + 1;
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    // Output range limits expressed at accumulator width for signed comparison.
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic fs_sync1;
    logic fs_sync2;
    logic fs_sync2_d;
    logic tick;

    logic [NUM_VOICES*SAMPLE_W-1:0] snap_sample;
    logic [NUM_VOICES*GAIN_W-1:0]   snap_gain;
    logic [NUM_VOICES-1:0]          snap_enable;
    logic signed [ACC_W-1:0]        acc;
    logic [IDX_W-1:0]               idx;

    logic signed [SAMPLE_W-1:0] cur_sample;
    logic [GAIN_W-1:0]          cur_gain;
    logic signed [GAIN_W:0]     gain_ext;
    logic signed [PROD_W-1:0]   product;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    shifted;
    logic                       sat_high;
    logic                       sat_low;
    logic                       clip_set;
    logic                       overrun_set;

    // FSCLK is asynchronous to Clk; two flops for metastability, a third for edge detect.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fs_sync1   <= 1'b0;
            fs_sync2   <= 1'b0;
            fs_sync2_d <= 1'b0;
            tick       <= 1'b0;
        end else begin
            fs_sync1   <= FSCLK;
            fs_sync2   <= fs_sync1;
            fs_sync2_d <= fs_sync2;
            tick       <= fs_sync2 & ~fs_sync2_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = ACCUM;
            ACCUM:   if (idx == LAST_IDX) state_next = SAT;
            SAT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    assign cur_sample = $signed(snap_sample[idx*SAMPLE_W +: SAMPLE_W]);
    assign cur_gain   = snap_gain[idx*GAIN_W +: GAIN_W];
    assign gain_ext   = $signed({1'b0, cur_gain});
    assign product    = PROD_W'(cur_sample) * PROD_W'(gain_ext);
    assign prod_ext   = ACC_W'(product);

    // Snapshot at frame start isolates the running mix from input changes mid-frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            snap_sample <= '0;
            snap_gain   <= '0;
            snap_enable <= '0;
            acc         <= '0;
            idx         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        snap_sample <= VoiceSample;
                        snap_gain   <= VoiceGain;
                        snap_enable <= VoiceEnable;
                        acc         <= '0;
                        idx         <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + (snap_enable[idx] ? prod_ext : '0);
                    idx <= idx + IDX_W'(1);
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

    assign shifted     = acc >>> GAIN_W;
    assign sat_high    = (shifted > OUT_MAX);
    assign sat_low     = (shifted < OUT_MIN);
    assign clip_set    = (state == SAT) && (sat_high || sat_low);
    assign overrun_set = tick && (state != IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Mix_Out   <= '0;
            Mix_Valid <= 1'b0;
        end else begin
            Mix_Valid <= 1'b0;
            if (state == SAT) begin
                Mix_Valid <= 1'b1;
                if (sat_high) begin
                    Mix_Out <= OUT_MAX[OUT_W-1:0];
                end else if (sat_low) begin
                    Mix_Out <= OUT_MIN[OUT_W-1:0];
                end else begin
                    Mix_Out <= shifted[OUT_W-1:0];
                end
            end
        end
    end

    // A new event outranks a simultaneous clear so no saturation or overrun is lost.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Clip    <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            if (clip_set) begin
                Clip <= 1'b1;
            end else if (Clear_Flags) begin
                Clip <= 1'b0;
            end

            if (overrun_set) begin
                Overrun <= 1'b1;
            end else if (Clear_Flags) begin
                Overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// tb_poly_voice_mixer: directed and randomized checks of poly_voice_mixer against an
// arithmetic mixing model (sum of sample*gain, floor-divide by 128, clamp to 16 bits).
module tb_poly_voice_mixer;

    localparam int NV = 4;
    localparam int SW = 16;
    localparam int GW = 7;
    localparam int OW = 16;
    // FSCLK rise driven before edge 1; 2 sync + 1 detect + 1 snapshot + 4 voices + 1 SAT.
    localparam int EXP_LATENCY = 9;

    logic                   Clk;
    logic                   Reset_n;
    logic                   FSCLK;
    logic [NV*SW-1:0]       VoiceSample;
    logic [NV*GW-1:0]       VoiceGain;
    logic [NV-1:0]          VoiceEnable;
    logic                   Clear_Flags;
    logic signed [OW-1:0]   Mix_Out;
    logic                   Mix_Valid;
    logic                   Busy;
    logic                   Clip;
    logic                   Overrun;

    int  tests_run    = 0;
    int  tests_failed = 0;
    int  smp [NV];
    int  gn  [NV];
    bit  en  [NV];
    bit  clip_exp    = 1'b0;
    bit  overrun_exp = 1'b0;

    poly_voice_mixer #(
        .NUM_VOICES(NV),
        .SAMPLE_W  (SW),
        .GAIN_W    (GW),
        .OUT_W     (OW)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .FSCLK      (FSCLK),
        .VoiceSample(VoiceSample),
        .VoiceGain  (VoiceGain),
        .VoiceEnable(VoiceEnable),
        .Clear_Flags(Clear_Flags),
        .Mix_Out    (Mix_Out),
        .Mix_Valid  (Mix_Valid),
        .Busy       (Busy),
        .Clip       (Clip),
        .Overrun    (Overrun)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_output(input string tag, input longint observed, input longint expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus();
        for (int i = 0; i < NV; i++) begin
            VoiceSample[i*SW +: SW] = 16'(smp[i]);
            VoiceGain[i*GW +: GW]   = 7'(gn[i]);
            VoiceEnable[i]          = en[i];
        end
    endtask

    task automatic scramble_inputs();
        VoiceSample = {$urandom, $urandom};
        VoiceGain   = 28'($urandom);
        VoiceEnable = 4'($urandom);
    endtask

    function automatic longint model_mix();
        longint sum;
        sum = 0;
        for (int i = 0; i < NV; i++) begin
            if (en[i]) sum += longint'(smp[i]) * longint'(gn[i]);
        end
        return sum >>> GW;
    endfunction

    function automatic longint clamp_mix(input longint s, output bit sat);
        sat = 1'b0;
        if (s > 32767) begin
            sat = 1'b1;
            return 32767;
        end
        if (s < -32768) begin
            sat = 1'b1;
            return -32768;
        end
        return s;
    endfunction

    task automatic set_voices(input int s0, input int g0, input bit e0,
                              input int s1, input int g1, input bit e1,
                              input int s2, input int g2, input bit e2,
                              input int s3, input int g3, input bit e3);
        smp[0] = s0; gn[0] = g0; en[0] = e0;
        smp[1] = s1; gn[1] = g1; en[1] = e1;
        smp[2] = s2; gn[2] = g2; en[2] = e2;
        smp[3] = s3; gn[3] = g3; en[3] = e3;
        apply_stimulus();
    endtask

    task automatic run_frame(input bit scramble, output int first_k, output int n_valid,
                             output logic signed [OW-1:0] got);
        first_k = -1;
        n_valid = 0;
        got     = '0;
        FSCLK   = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (Mix_Valid) begin
                n_valid++;
                if (first_k < 0) begin
                    first_k = k;
                    got     = Mix_Out;
                end
            end
            if (k == 3) FSCLK = 1'b0;
            if (k == 4 && scramble) scramble_inputs();
        end
    endtask

    task automatic frame_and_check(input string tag, input bit scramble);
        longint exp_mix;
        bit     sat;
        int     first_k;
        int     n_valid;
        logic signed [OW-1:0] got;
        exp_mix  = clamp_mix(model_mix(), sat);
        clip_exp = clip_exp | sat;
        run_frame(scramble, first_k, n_valid, got);
        check_output({tag, "_latency"}, first_k, EXP_LATENCY);
        check_output({tag, "_valid_count"}, n_valid, 1);
        check_output({tag, "_mix_out"}, longint'(got), exp_mix);
        check_output({tag, "_mix_held"}, longint'(Mix_Out), exp_mix);
        check_output({tag, "_clip"}, longint'(Clip), longint'(clip_exp));
        check_output({tag, "_overrun"}, longint'(Overrun), longint'(overrun_exp));
        check_output({tag, "_busy_idle"}, longint'(Busy), 0);
    endtask

    task automatic clear_flags(input string tag);
        Clear_Flags = 1'b1;
        step();
        Clear_Flags = 1'b0;
        clip_exp    = 1'b0;
        overrun_exp = 1'b0;
        check_output({tag, "_clip"}, longint'(Clip), 0);
        check_output({tag, "_overrun"}, longint'(Overrun), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_mix_out"}, longint'(Mix_Out), 0);
        check_output({tag, "_mix_valid"}, longint'(Mix_Valid), 0);
        check_output({tag, "_busy"}, longint'(Busy), 0);
        check_output({tag, "_clip"}, longint'(Clip), 0);
        check_output({tag, "_overrun"}, longint'(Overrun), 0);
    endtask

    initial begin
        int     n_valid;
        longint exp_mix;
        bit     sat;
        logic signed [OW-1:0] got;

        Reset_n     = 1'b0;
        FSCLK       = 1'b0;
        Clear_Flags = 1'b0;
        scramble_inputs();
        repeat (3) step();
        check_all_zero("reset_held");
        Reset_n = 1'b1;
        repeat (6) step();
        check_all_zero("reset_released");

        set_voices(1000, 64, 1, 1234, 100, 0, -555, 77, 0, 32000, 127, 0);
        frame_and_check("single_voice", 1'b0);

        set_voices(32767, 127, 1, 32767, 127, 1, 32767, 127, 1, 32767, 127, 1);
        frame_and_check("pos_sat", 1'b0);
        set_voices(-32768, 127, 1, -32768, 127, 1, -32768, 127, 1, -32768, 127, 1);
        frame_and_check("neg_sat", 1'b0);
        clear_flags("clear_after_sat");

        set_voices(-3, 1, 1, 500, 90, 0, -700, 12, 0, 42, 5, 0);
        frame_and_check("floor_round", 1'b0);
        set_voices(300, 127, 1, -300, 127, 1, 9999, 50, 0, -9999, 60, 0);
        frame_and_check("mixed_cancel", 1'b0);
        set_voices(12345, 0, 1, -23456, 0, 1, 32767, 0, 1, -32768, 0, 1);
        frame_and_check("zero_gain", 1'b0);
        set_voices(12345, 99, 0, -23456, 88, 0, 32767, 77, 0, -32768, 66, 0);
        frame_and_check("all_disabled", 1'b0);

        // Second FSCLK rise lands while the first frame is still accumulating.
        set_voices(4000, 100, 1, -1500, 60, 1, 2500, 127, 1, 800, 20, 1);
        exp_mix  = clamp_mix(model_mix(), sat);
        clip_exp = clip_exp | sat;
        n_valid  = 0;
        got      = '0;
        FSCLK    = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (Mix_Valid) begin
                n_valid++;
                got = Mix_Out;
            end
            if (k == 2) FSCLK = 1'b0;
            if (k == 4) FSCLK = 1'b1;
            if (k == 6) FSCLK = 1'b0;
        end
        overrun_exp = 1'b1;
        check_output("overrun_valid_count", n_valid, 1);
        check_output("overrun_mix_out", longint'(got), exp_mix);
        check_output("overrun_flag", longint'(Overrun), 1);
        check_output("overrun_clip", longint'(Clip), longint'(clip_exp));
        clear_flags("clear_after_overrun");

        // Abort in the second accumulate cycle; the prior nonzero Mix_Out must be cleared.
        set_voices(20000, 127, 1, 20000, 127, 1, -100, 3, 1, 7, 9, 1);
        FSCLK = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 3) FSCLK = 1'b0;
        end
        Reset_n = 1'b0;
        #1;
        clip_exp    = 1'b0;
        overrun_exp = 1'b0;
        check_all_zero("midframe_reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        n_valid = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (Mix_Valid) n_valid++;
        end
        check_output("midframe_no_valid", n_valid, 0);
        check_output("midframe_mix_zero", longint'(Mix_Out), 0);
        frame_and_check("after_abort", 1'b0);

        for (int f = 0; f < 24; f++) begin
            for (int i = 0; i < NV; i++) begin
                smp[i] = int'($urandom_range(0, 65535)) - 32768;
                if ($urandom_range(0, 1) == 1) smp[i] = smp[i] / 8;
                gn[i]  = int'($urandom_range(0, 127));
                en[i]  = bit'($urandom_range(0, 1));
            end
            apply_stimulus();
            frame_and_check($sformatf("random_%0d", f), 1'b1);
            if ($urandom_range(0, 3) == 0) clear_flags($sformatf("random_clear_%0d", f));
        end

        // FSCLK already high when reset releases must still produce exactly one frame.
        set_voices(-8000, 64, 1, 3000, 32, 1, 0, 0, 0, 111, 127, 1);
        @(negedge Clk);
        Reset_n = 1'b0;
        FSCLK   = 1'b1;
        step();
        step();
        clip_exp    = 1'b0;
        overrun_exp = 1'b0;
        Reset_n     = 1'b1;
        frame_and_check("high_at_release", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
